// File: rtl/wb_reg_slave_pkg.sv
// Shared sizing and types for the Wishbone register slave.
// The module parameters default to these values.
package wb_core_2_pkg;

    localparam int unsigned ADDR_WIDTH   = 16;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned GRANULE      = 8;
    localparam int unsigned REGISTER_NUM = 16;
    localparam int unsigned SEL_WIDTH    = DATA_WIDTH / GRANULE;
    localparam int unsigned IDX_WIDTH    = $clog2(REGISTER_NUM);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

endpackage

// File: rtl/wb_reg_bank.sv
// Register array with byte-lane write enables and a combinational read port.
// Reads and writes share one index because the slave handles one request at a time.
module wb_reg_bank #(
    parameter int unsigned DATA_WIDTH   = wb_core_2_pkg::DATA_WIDTH,
    parameter int unsigned GRANULE      = wb_core_2_pkg::GRANULE,
    parameter int unsigned REGISTER_NUM = wb_core_2_pkg::REGISTER_NUM,
    localparam int unsigned SEL_WIDTH   = DATA_WIDTH / GRANULE,
    localparam int unsigned IDX_WIDTH   = $clog2(REGISTER_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] regs [REGISTER_NUM];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int r = 0; r < REGISTER_NUM; r++) begin
                regs[r] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
                if (sel[k]) begin
                    regs[idx][k*GRANULE +: GRANULE] <= wr_data[k*GRANULE +: GRANULE];
                end
            end
        end
    end

    assign rd_data = regs[idx];

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone B4 pipelined slave over a bank of 32-bit control/status registers.
// One request per cycle, registered ack/err one cycle later, no back-pressure.
module wb_reg_slave #(
    parameter int unsigned ADDR_WIDTH   = wb_core_2_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = wb_core_2_pkg::DATA_WIDTH,
    parameter int unsigned GRANULE      = wb_core_2_pkg::GRANULE,
    parameter int unsigned REGISTER_NUM = wb_core_2_pkg::REGISTER_NUM,
    localparam int unsigned SEL_WIDTH   = DATA_WIDTH / GRANULE,
    localparam int unsigned IDX_WIDTH   = $clog2(REGISTER_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o
);

    logic                  accept;
    logic                  addr_err;
    logic                  bank_we;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dat_q;

    assign stall_o = ~rst_i;
    assign accept  = cyc_i & stb_i & ~stall_o;

    // Misaligned addresses and anything past the last register are rejected.
    assign idx      = adr_i[2 +: IDX_WIDTH];
    assign addr_err = (adr_i[1:0] != 2'b00) || ((adr_i >> (IDX_WIDTH + 2)) != '0);
    assign bank_we  = accept & we_i & ~addr_err;

    wb_reg_bank #(
        .DATA_WIDTH   (DATA_WIDTH),
        .GRANULE      (GRANULE),
        .REGISTER_NUM (REGISTER_NUM)
    ) u_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we      (bank_we),
        .sel     (sel_i),
        .idx     (idx),
        .wr_data (dat_i),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept & ~addr_err;
            err_q <= accept & addr_err;
            dat_q <= (accept & ~we_i & ~addr_err) ? rd_data : '0;
        end
    end

    // Gating with rst_i drops a response whose cycle coincides with reset assertion.
    assign ack_o = ack_q & rst_i;
    assign err_o = err_q & rst_i;
    assign dat_o = rst_i ? dat_q : '0;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed vector bench for wb_reg_slave: each row is one bus cycle; its stall
// is checked in the same cycle and its response in the following cycle.
module tb_wb_reg_slave;
    import wb_core_2_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    data_t                 dat_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    data_t                 dat_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  stall_o;

    always #5 clk_i = ~clk_i;

    wb_reg_slave dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .sel_i   (sel_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .stall_o (stall_o)
    );

    typedef struct {
        logic                  rst;
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        data_t                 dat;
        logic [SEL_WIDTH-1:0]  sel;
        logic                  exp_stall;
        logic                  exp_ack;
        logic                  exp_err;
        data_t                 exp_dat;
    } vec_t;

    vec_t vq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic add(input logic rst, input logic cyc, input logic stb, input logic we,
                       input logic [ADDR_WIDTH-1:0] adr, input data_t dat,
                       input logic [SEL_WIDTH-1:0] sel,
                       input logic ack, input logic err, input data_t rdat);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we;
        v.adr = adr; v.dat = dat; v.sel = sel;
        v.exp_stall = ~rst;
        v.exp_ack = ack; v.exp_err = err; v.exp_dat = rdat;
        vq.push_back(v);
    endtask

    task automatic wr(input logic [ADDR_WIDTH-1:0] adr, input data_t dat, input logic [SEL_WIDTH-1:0] sel);
        add(1'b1, 1'b1, 1'b1, 1'b1, adr, dat, sel, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [ADDR_WIDTH-1:0] adr, input data_t exp);
        add(1'b1, 1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hF, 1'b1, 1'b0, exp);
    endtask

    task automatic bad(input logic we, input logic [ADDR_WIDTH-1:0] adr, input data_t dat);
        add(1'b1, 1'b1, 1'b1, we, adr, dat, 4'hF, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic idle(input logic rst);
        add(rst, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drive(input vec_t v);
        rst_i = v.rst; cyc_i = v.cyc; stb_i = v.stb; we_i = v.we;
        adr_i = v.adr; dat_i = v.dat; sel_i = v.sel;
    endtask

    task automatic chk1(input int row, input string name, input logic act, input logic exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL row %0d %s: got %b expected %b", row, name, act, exp);
        end
    endtask

    initial begin
        vec_t  cur;
        vec_t  prev;
        vec_t  nop;

        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; dat_i = '0; sel_i = '0;

        // reset held two cycles, then every register reads zero
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 16; i++) rd(16'(i * 4), 32'h0);

        wr(16'h0008, 32'hDEADBEEF, 4'hF);
        rd(16'h0008, 32'hDEADBEEF);

        // byte lanes, read immediately after write, empty select
        wr(16'h0004, 32'h11223344, 4'hF);
        wr(16'h0004, 32'hAABBCCDD, 4'b0101);
        rd(16'h0004, 32'h11BB33DD);
        wr(16'h0004, 32'hFFFFFFFF, 4'h0);
        rd(16'h0004, 32'h11BB33DD);
        wr(16'h0008, 32'h00FF0000, 4'b1100);
        rd(16'h0008, 32'h00FFBEEF);

        // decode errors and the legal upper edge
        bad(1'b0, 16'h0040, 32'h0);
        bad(1'b1, 16'h0002, 32'h12345678);
        rd(16'h0000, 32'h0);
        bad(1'b0, 16'h000A, 32'h0);
        bad(1'b1, 16'h8004, 32'hFFFFFFFF);
        rd(16'h0004, 32'h11BB33DD);
        wr(16'h003C, 32'h3C3C3C3C, 4'hF);
        rd(16'h003C, 32'h3C3C3C3C);

        // stb without cyc, and cyc without stb, are not requests
        add(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 32'h99999999, 4'hF, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h88888888, 4'hF, 1'b0, 1'b0, 32'h0);
        rd(16'h0010, 32'h0);

        // pipelined burst: six back-to-back acks
        wr(16'h0000, 32'hA0A0A0A0, 4'hF);
        wr(16'h0004, 32'hB1B1B1B1, 4'hF);
        wr(16'h0008, 32'hC2C2C2C2, 4'hF);
        rd(16'h0000, 32'hA0A0A0A0);
        rd(16'h0004, 32'hB1B1B1B1);
        rd(16'h0008, 32'hC2C2C2C2);
        idle(1'b1);

        // write accepted, reset asserted in its response cycle: no ack, register cleared
        add(1'b1, 1'b1, 1'b1, 1'b1, 16'h000C, 32'h55555555, 4'hF, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        rd(16'h000C, 32'h0);
        rd(16'h0008, 32'h0);
        idle(1'b1);

        nop.rst = 1'b1; nop.cyc = 1'b0; nop.stb = 1'b0; nop.we = 1'b0;
        nop.adr = '0; nop.dat = '0; nop.sel = '0;
        nop.exp_stall = 1'b0; nop.exp_ack = 1'b0; nop.exp_err = 1'b0; nop.exp_dat = '0;

        for (int i = 0; i <= vq.size(); i++) begin
            cur = (i < vq.size()) ? vq[i] : nop;
            @(negedge clk_i);
            drive(cur);
            #1;
            vectors++;
            chk1(i, "stall_o", stall_o, cur.exp_stall);
            if (i > 0) begin
                prev = vq[i-1];
                chk1(i, "ack_o", ack_o, prev.exp_ack);
                chk1(i, "err_o", err_o, prev.exp_err);
                if (dat_o !== prev.exp_dat) begin
                    miscompares++;
                    $display("FAIL row %0d dat_o: got %h expected %h", i, dat_o, prev.exp_dat);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_reg_slave.md
Name: wb_reg_slave

Overview:
- Wishbone B4 pipelined slave exposing a bank of REGISTER_NUM 32-bit read/write registers with byte-lane write enables.
- Sits behind a Wishbone master/interconnect as a simple control/status register block.
- Accepts one request per cycle, responds one cycle later with ack_o or err_o.

Parameters:
- ADDR_WIDTH, 16, width of the adr_i byte address.
- DATA_WIDTH, 32, data bus width.
- GRANULE, 8, bits per select lane.
- REGISTER_NUM, 16, number of registers.
- SEL_WIDTH, DATA_WIDTH/GRANULE (4), localparam: number of byte-select lines.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  SEL_WIDTH  byte-lane select; sel_i[k] covers dat bits [8k+7:8k].
- dat_o  out  DATA_WIDTH  read data, valid only while ack_o=1.
- ack_o  out  1  successful completion.
- err_o  out  1  error completion.
- stall_o  out  1  slave cannot accept a request this cycle.

Behaviour:
Reset
- One clock; reset is synchronous and active-low: rst_i=0 sampled on a clk_i rising edge resets the block.
- On reset: all registers = 0, ack_o = 0, err_o = 0, dat_o = 0.
- stall_o = 1 while rst_i = 0, otherwise stall_o = 0. No back-pressure in normal operation.
- A request in flight when reset asserts is dropped: no ack_o or err_o is issued.

Acceptance and response
- A request is accepted on an edge where cyc_i & stb_i & ~stall_o.
- Response is registered, so latency is exactly 1 cycle: ack_o or err_o is high for exactly one cycle after each accepted request.
- Back-to-back requests give back-to-back responses, one per cycle, in order.
- ack_o and err_o are never high together.
- stb_i high with cyc_i low is ignored.
- If cyc_i is low in the response cycle, the response is still driven for that one cycle, and the master disregards it.

Address decode
- Register index = adr_i[2 +: log2(REGISTER_NUM)].
- Error condition: adr_i[1:0] != 0, or any adr_i bit above the index field is set, so the legal range is 0x0000..0x003C.
- An erroring request produces err_o=1 and dat_o=0, and no register is modified.

Write (we_i=1, legal address)
- For each k with sel_i[k]=1, reg[idx] byte k = dat_i byte k. Other bytes are unchanged.
- sel_i=0 is legal: it is acknowledged and writes nothing.
- ack_o=1 the next cycle; dat_o=0.

Read (we_i=0, legal address)
- dat_o = full reg[idx] in the ack cycle, regardless of sel_i.
- A read issued in the cycle right after a write to the same register returns the updated value, because the write commits at the accept edge.

Idle
- dat_o = 0 whenever ack_o = 0.

Decomposition:
- Package wb_core_2_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, GRANULE, REGISTER_NUM.
  - SEL_WIDTH and IDX_WIDTH = $clog2(REGISTER_NUM).
  - A typedef for the data word and one for the register index.
- Sub-module wb_reg_bank: register array with per-byte write enable and a combinational read port.
- The top level handles handshake, decode and the response registers.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles, then read all 16 registers (adr 0x00..0x3C) -> each ack_o=1 one cycle later with dat_o=0x00000000; stall_o=1 during reset.
- Full write/read: write 0xDEADBEEF, sel=4'hF to adr 0x0008, then read 0x0008 -> ack_o for both; read dat_o=0xDEADBEEF.
- Byte lanes: reg 0x0004 = 0x11223344, then write 0xAABBCCDD with sel=4'b0101 -> a subsequent read returns 0x11BB33DD.
- Errors: read adr 0x0040 -> err_o=1, ack_o=0, dat_o=0. Write adr 0x0002 -> err_o=1 and no register changes, so a read of 0x0000 is unchanged.
- Pipelining: writes to 0x00, 0x04, 0x08 on consecutive cycles, then three consecutive reads -> ack_o high for 6 consecutive cycles, stall_o=0 throughout, reads return the written data in order.
- Mid-operation reset: accept a write to 0x000C while rst_i drops on the next edge -> no ack_o, and a read after release returns 0.
